// File: rtl/vmicro16_reset_ctrl_pkg.sv
// Shared definitions for the vmicro16 reset controller.
//   rst_state_e : sequencer states (power-on, hold, staggered release, run)
//   max4        : elaboration-time helper used to size the shared counter
package vmicro16_reset_ctrl_pkg;

    typedef enum logic [1:0] {
        StPor     = 2'd0,
        StHold    = 2'd1,
        StRelease = 2'd2,
        StRun     = 2'd3
    } rst_state_e;

    function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/vmicro16_reset_ctrl_sync_deb.sv
// One reset-request input path: 2-FF synchroniser, optional inversion so the
// output is always active-high, and an optional debouncer.
//   i_clk    system clock
//   i_reset  asynchronous active-high reset
//   i_raw    raw request pin, asynchronous to i_clk
//   o_req    synchronised (and optionally debounced) active-high request
module vmicro16_reset_ctrl_sync_deb #(
    parameter logic        INV      = 1'b0,
    parameter logic        DEB      = 1'b0,
    parameter int unsigned DEB_CLKS = 4,
    parameter int unsigned CNT_W    = 3
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_raw,
    output logic o_req
);

    logic r_ff1;
    logic r_ff2;
    logic w_active;

    // Synchroniser resets to the idle pin level so reset exit never looks
    // like a request on an active-low input.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ff1 <= INV;
            r_ff2 <= INV;
        end else begin
            r_ff1 <= i_raw;
            r_ff2 <= r_ff1;
        end
    end

    assign w_active = r_ff2 ^ INV;

    if (DEB) begin : g_deb
        logic             r_level;
        logic [CNT_W-1:0] r_cnt;

        // The level flips only after DEB_CLKS consecutive cycles that differ
        // from it; any agreeing cycle restarts the count.
        always_ff @(posedge i_clk or posedge i_reset) begin
            if (i_reset) begin
                r_level <= 1'b0;
                r_cnt   <= '0;
            end else if (w_active == r_level) begin
                r_cnt   <= '0;
            end else if (r_cnt == CNT_W'(DEB_CLKS - 1)) begin
                r_level <= w_active;
                r_cnt   <= '0;
            end else begin
                r_cnt   <= r_cnt + CNT_W'(1);
            end
        end

        assign o_req = r_level;
    end else begin : g_nodeb
        assign o_req = w_active;
    end

endmodule

// File: rtl/vmicro16_reset_ctrl.sv
// SoC reset controller. Merges the asynchronous board/POR reset with NUM_SRC
// request inputs and releases NUM_OUT domain resets one after another,
// STAGGER_CLKS apart, after a power-on wait and a quiet hold period.
//   i_clk        system clock
//   i_reset      asynchronous active-high board/POR reset
//   i_src_req    raw reset requests (polarity per SRC_INV)
//   i_cause_clr  sync pulse clearing o_rst_cause (a same-cycle set wins per bit)
//   o_rst_out    active-high domain resets, bit 0 released first
//   o_ready      high once every domain is out of reset
//   o_rst_cause  sticky causes: bit i = source i, bit NUM_SRC = POR/board reset
module vmicro16_reset_ctrl
    import vmicro16_reset_ctrl_pkg::*;
#(
    parameter int unsigned       POR_CLKS     = 8,
    parameter int unsigned       HOLD_CLKS    = 16,
    parameter int unsigned       STAGGER_CLKS = 4,
    parameter int unsigned       NUM_SRC      = 2,
    parameter int unsigned       NUM_OUT      = 3,
    parameter logic [NUM_SRC-1:0] SRC_INV     = 2'b01,
    parameter logic [NUM_SRC-1:0] DEB_MASK    = 2'b01,
    parameter int unsigned       DEB_CLKS     = 4
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NUM_SRC-1:0] i_src_req,
    input  logic               i_cause_clr,
    output logic [NUM_OUT-1:0] o_rst_out,
    output logic               o_ready,
    output logic [NUM_SRC:0]   o_rst_cause
);

    localparam int unsigned CntW = $clog2(max4(POR_CLKS, HOLD_CLKS, STAGGER_CLKS, DEB_CLKS) + 1);
    localparam int unsigned IdxW = $clog2(NUM_OUT + 1);

    localparam logic [CntW-1:0] PorLast  = CntW'(POR_CLKS - 1);
    localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_CLKS - 1);
    localparam logic [CntW-1:0] StagLast = CntW'(STAGGER_CLKS - 1);
    localparam logic [IdxW-1:0] IdxLast  = IdxW'(NUM_OUT - 1);

    logic [NUM_SRC-1:0] w_req;
    logic               w_req_any;

    rst_state_e         r_state, w_state_d;
    logic [CntW-1:0]    r_cnt, w_cnt_d;
    logic [IdxW-1:0]    r_idx, w_idx_d;
    logic [NUM_OUT-1:0] r_rst, w_rst_d;
    logic               r_ready, w_ready_d;
    logic [NUM_SRC:0]   r_cause, w_cause_d;
    logic [NUM_SRC:0]   w_cause_set;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        vmicro16_reset_ctrl_sync_deb #(
            .INV      (SRC_INV[i]),
            .DEB      (DEB_MASK[i]),
            .DEB_CLKS (DEB_CLKS),
            .CNT_W    (CntW)
        ) u_sync_deb (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_raw   (i_src_req[i]),
            .o_req   (w_req[i])
        );
    end

    assign w_req_any   = |w_req;
    assign w_cause_set = {1'b0, w_req};

    // State register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= StPor;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_rst   <= '1;
            r_ready <= 1'b0;
            r_cause <= {1'b1, {NUM_SRC{1'b0}}};
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_idx   <= w_idx_d;
            r_rst   <= w_rst_d;
            r_ready <= w_ready_d;
            r_cause <= w_cause_d;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_idx_d   = r_idx;
        w_rst_d   = r_rst;
        w_ready_d = r_ready;

        unique case (r_state)
            StPor: begin
                if (r_cnt == PorLast) begin
                    w_state_d = StHold;
                    w_cnt_d   = '0;
                end else begin
                    w_cnt_d   = r_cnt + CntW'(1);
                end
            end
            StHold: begin
                if (w_req_any) begin
                    w_cnt_d   = '0;
                end else if (r_cnt == HoldLast) begin
                    w_state_d = StRelease;
                    w_cnt_d   = '0;
                    w_idx_d   = '0;
                end else begin
                    w_cnt_d   = r_cnt + CntW'(1);
                end
            end
            StRelease: begin
                if (r_cnt == StagLast) begin
                    for (int k = 0; k < NUM_OUT; k++) begin
                        if (r_idx == IdxW'(k)) w_rst_d[k] = 1'b0;
                    end
                    w_idx_d = r_idx + IdxW'(1);
                    w_cnt_d = '0;
                    if (r_idx == IdxLast) w_state_d = StRun;
                end else begin
                    w_cnt_d = r_cnt + CntW'(1);
                end
            end
            StRun: begin
                // ready trails the last domain release by one edge
                w_ready_d = 1'b1;
            end
            default: begin
                w_state_d = StPor;
            end
        endcase

        // Outside power-on, any request re-asserts every domain at once and
        // restarts the hold period, including part-way through a release.
        if (r_state != StPor && w_req_any) begin
            w_state_d = StHold;
            w_cnt_d   = '0;
            w_rst_d   = '1;
            w_ready_d = 1'b0;
        end
    end

    // Cause record: a source active this cycle survives a same-cycle clear.
    always_comb begin
        w_cause_d = i_cause_clr ? w_cause_set : (r_cause | w_cause_set);
    end

    // Outputs
    always_comb begin
        o_rst_out   = r_rst;
        o_ready     = r_ready;
        o_rst_cause = r_cause;
    end

endmodule

// File: tb/tb_vmicro16_reset_ctrl.sv
module tb_vmicro16_reset_ctrl;

    typedef struct {
        int         at;
        logic [2:0] val;
        logic       rdy;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] src_req = 2'b01;
    logic       cause_clr = 1'b0;
    logic [2:0] rst_out;
    logic       ready;
    logic [2:0] rst_cause;

    logic [1:0] src_idle1 = 2'b01;
    logic       clr1 = 1'b0;
    logic [0:0] rst_out1;
    logic       ready1;
    logic [2:0] rst_cause1;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    exp_t q_main[$];
    exp_t q_cause[$];
    exp_t q_d1[$];

    logic [3:0] prev_main;
    logic [2:0] prev_cause;
    logic [1:0] prev_d1;

    vmicro16_reset_ctrl dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_src_req   (src_req),
        .i_cause_clr (cause_clr),
        .o_rst_out   (rst_out),
        .o_ready     (ready),
        .o_rst_cause (rst_cause)
    );

    vmicro16_reset_ctrl #(
        .NUM_OUT      (1),
        .STAGGER_CLKS (1)
    ) dut1 (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_src_req   (src_idle1),
        .i_cause_clr (clr1),
        .o_rst_out   (rst_out1),
        .o_ready     (ready1),
        .o_rst_cause (rst_cause1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every output change pops the next expected event.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            prev_main  = {rst_out, ready};
            prev_cause = rst_cause;
            prev_d1    = {rst_out1, ready1};
        end else begin
            if ({rst_out, ready} !== prev_main) begin
                n_tests++;
                if (q_main.size() == 0) begin
                    n_fail++;
                    $display("FAIL main_unexpected: rst_out=%b ready=%b at cyc %0d, none expected",
                             rst_out, ready, cyc);
                end else begin
                    e = q_main.pop_front();
                    if (e.at != cyc || e.val !== rst_out || e.rdy !== ready) begin
                        n_fail++;
                        $display("FAIL main_event: got rst_out=%b ready=%b cyc %0d, want %b %b cyc %0d",
                                 rst_out, ready, cyc, e.val, e.rdy, e.at);
                    end
                end
                prev_main = {rst_out, ready};
            end
            if (rst_cause !== prev_cause) begin
                n_tests++;
                if (q_cause.size() == 0) begin
                    n_fail++;
                    $display("FAIL cause_unexpected: rst_cause=%b at cyc %0d, none expected",
                             rst_cause, cyc);
                end else begin
                    e = q_cause.pop_front();
                    if (e.at != cyc || e.val !== rst_cause) begin
                        n_fail++;
                        $display("FAIL cause_event: got %b cyc %0d, want %b cyc %0d",
                                 rst_cause, cyc, e.val, e.at);
                    end
                end
                prev_cause = rst_cause;
            end
            if ({rst_out1, ready1} !== prev_d1) begin
                n_tests++;
                if (q_d1.size() == 0) begin
                    n_fail++;
                    $display("FAIL d1_unexpected: rst_out=%b ready=%b at cyc %0d, none expected",
                             rst_out1, ready1, cyc);
                end else begin
                    e = q_d1.pop_front();
                    if (e.at != cyc || e.val[0] !== rst_out1[0] || e.rdy !== ready1) begin
                        n_fail++;
                        $display("FAIL d1_event: got rst_out=%b ready=%b cyc %0d, want %b %b cyc %0d",
                                 rst_out1, ready1, cyc, e.val[0], e.rdy, e.at);
                    end
                end
                prev_d1 = {rst_out1, ready1};
            end
        end
    end

    task automatic push_main(input int at, input logic [2:0] v, input logic r);
        exp_t e;
        e.at = at; e.val = v; e.rdy = r;
        q_main.push_back(e);
    endtask

    task automatic push_cause(input int at, input logic [2:0] v);
        exp_t e;
        e.at = at; e.val = v; e.rdy = 1'b0;
        q_cause.push_back(e);
    endtask

    task automatic push_d1(input int at, input logic v, input logic r);
        exp_t e;
        e.at = at; e.val = {2'b00, v}; e.rdy = r;
        q_d1.push_back(e);
    endtask

    // Events after a request last seen by the FSM at edge E (defaults).
    task automatic push_release(input int e_edge);
        push_main(e_edge + 20, 3'b110, 1'b0);
        push_main(e_edge + 24, 3'b100, 1'b0);
        push_main(e_edge + 28, 3'b000, 1'b0);
        push_main(e_edge + 29, 3'b000, 1'b1);
    endtask

    task automatic push_por(input int t0);
        push_release(t0 + 8);
        push_d1(t0 + 25, 1'b0, 1'b0);
        push_d1(t0 + 26, 1'b0, 1'b1);
    endtask

    task automatic check3(input string name, input logic [2:0] act, input logic [2:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    initial begin
        int t0;
        int c;
        int d;

        // Reset state
        repeat (2) @(negedge clk);
        check3("reset_rst_out", rst_out, 3'b111);
        check3("reset_ready", {2'b00, ready}, 3'b000);
        check3("reset_cause", rst_cause, 3'b100);

        // 1: power-up, sources idle
        @(negedge clk);
        reset = 1'b0;
        t0 = cyc;
        push_por(t0);
        wait_cyc(t0 + 40);
        check3("por_cause", rst_cause, 3'b100);

        // 2: single-cycle pulse on the non-debounced source
        @(negedge clk);
        c = cyc;
        src_req[1] = 1'b1;
        push_main(c + 3, 3'b111, 1'b0);
        push_cause(c + 3, 3'b110);
        push_release(c + 3);
        @(negedge clk);
        src_req[1] = 1'b0;
        wait_cyc(c + 40);

        // 3a: three-cycle glitch on the debounced active-low source is filtered
        @(negedge clk);
        src_req[0] = 1'b0;
        repeat (3) @(negedge clk);
        src_req[0] = 1'b1;
        repeat (10) @(negedge clk);

        // 3b: six-cycle low is accepted; released 4 stable cycles after it ends
        c = cyc;
        src_req[0] = 1'b0;
        push_main(c + 7, 3'b111, 1'b0);
        push_cause(c + 7, 3'b111);
        push_main(c + 32, 3'b110, 1'b0);
        push_main(c + 36, 3'b100, 1'b0);
        repeat (6) @(negedge clk);
        src_req[0] = 1'b1;

        // 4: request lands with two domains released; everything restarts
        wait_cyc(c + 34);
        d = cyc;
        src_req[1] = 1'b1;
        push_main(d + 3, 3'b111, 1'b0);
        push_release(d + 3);
        @(negedge clk);
        src_req[1] = 1'b0;
        wait_cyc(d + 40);

        // 5: clear coincident with a source set, then clear alone
        @(negedge clk);
        d = cyc;
        src_req[1] = 1'b1;
        push_main(d + 3, 3'b111, 1'b0);
        push_cause(d + 3, 3'b010);
        push_main(d + 23, 3'b110, 1'b0);
        push_main(d + 27, 3'b100, 1'b0);
        @(negedge clk);
        src_req[1] = 1'b0;
        @(negedge clk);
        cause_clr = 1'b1;
        @(negedge clk);
        cause_clr = 1'b0;
        wait_cyc(d + 10);
        c = cyc;
        cause_clr = 1'b1;
        push_cause(c + 1, 3'b000);
        @(negedge clk);
        cause_clr = 1'b0;

        // 6: async reset mid-release takes effect with no clock edge
        wait_cyc(d + 28);
        #2 reset = 1'b1;
        #1;
        check3("async_rst_out", rst_out, 3'b111);
        check3("async_ready", {2'b00, ready}, 3'b000);
        check3("async_cause", rst_cause, 3'b100);
        check3("async_d1_rst_out", {2'b00, rst_out1}, 3'b001);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        t0 = cyc;
        push_por(t0);

        // Drain, bounded
        for (int i = 0; i < 200; i++) begin
            if (q_main.size() == 0 && q_cause.size() == 0 && q_d1.size() == 0) break;
            @(negedge clk);
        end
        while (q_main.size() > 0) begin
            exp_t e;
            e = q_main.pop_front();
            n_tests++; n_fail++;
            $display("FAIL main_missing: no change seen, want rst_out=%b ready=%b cyc %0d",
                     e.val, e.rdy, e.at);
        end
        while (q_cause.size() > 0) begin
            exp_t e;
            e = q_cause.pop_front();
            n_tests++; n_fail++;
            $display("FAIL cause_missing: no change seen, want %b cyc %0d", e.val, e.at);
        end
        while (q_d1.size() > 0) begin
            exp_t e;
            e = q_d1.pop_front();
            n_tests++; n_fail++;
            $display("FAIL d1_missing: no change seen, want rst_out=%b ready=%b cyc %0d",
                     e.val[0], e.rdy, e.at);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
